// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART transmit arbiter.
// The round-robin pick works on a fixed 8-bit request vector; narrower users zero-extend.
package uart_pkg;

  localparam int UART_BYTE_W = 8;
  localparam int MAX_REQ     = 8;
  localparam int IDX_W       = 3;

  typedef enum logic [0:0] {
    ARB  = 1'b0,
    LOCK = 1'b1
  } arb_state_t;

  // First set request strictly after last_gnt, wrapping within n_req requesters.
  function automatic logic [MAX_REQ-1:0] rr_pick(
    input logic [MAX_REQ-1:0] req,
    input logic [IDX_W-1:0]   last_gnt,
    input int                 n_req
  );
    logic [MAX_REQ-1:0] gnt;
    logic               found;
    logic [3:0]         idx;
    logic [3:0]         n4;
    gnt   = {MAX_REQ{1'b0}};
    found = 1'b0;
    n4    = 4'(n_req);
    for (int k = 1; k <= MAX_REQ; k++) begin
      idx = {1'b0, last_gnt} + 4'(k);
      if (idx >= n4) begin
        idx = idx - n4;
      end else begin
        idx = idx;
      end
      if ((4'(k) <= n4) && !found && req[idx[2:0]]) begin
        gnt[idx[2:0]] = 1'b1;
        found         = 1'b1;
      end else begin
        found = found;
      end
    end
    return gnt;
  endfunction

endpackage

// File: rtl/uart_tx_arb_rr_arbiter.sv
// Combinational round-robin pick: one-hot grant plus its index from a request
// vector and the previous owner's index.
module rr_arbiter
  import uart_pkg::*;
#(
  parameter int N_REQ = 4
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] last_gnt,
  output logic [N_REQ-1:0] gnt,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             any
);

  logic [MAX_REQ-1:0] req_ext;
  logic [MAX_REQ-1:0] pick;

  always_comb begin
    req_ext = MAX_REQ'(req);
    pick    = rr_pick(req_ext, last_gnt, N_REQ);
    gnt     = pick[N_REQ-1:0];
    any     = |pick;
    gnt_idx = {IDX_W{1'b0}};
    for (int i = 0; i < N_REQ; i++) begin
      gnt_idx = gnt_idx | (pick[i] ? IDX_W'(i) : {IDX_W{1'b0}});
    end
  end

endmodule

// File: rtl/uart_tx_arb.sv
// Packet-locked round-robin arbiter feeding one uart_tx byte interface.
// Optional mid-packet stall release is enabled with `define UART_ARB_TIMEOUT_EN.
module uart_tx_arb
  import uart_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int TIMEOUT = 1024
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [N_REQ-1:0]             req_val_i,
  input  logic [UART_BYTE_W*N_REQ-1:0] req_data_i,
  input  logic [N_REQ-1:0]             req_last_i,
  output logic [N_REQ-1:0]             req_rdy_o,
  output logic                         tx_val_o,
  output logic [UART_BYTE_W-1:0]       tx_data_o,
  input  logic                         tx_rdy_i,
  output logic [N_REQ-1:0]             grant_o,
  output logic                         busy_o,
  output logic                         timeout_o
);

  localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(N_REQ - 1);

  if (N_REQ < 1 || N_REQ > MAX_REQ || TIMEOUT < 1) begin : g_bad_param
    $error("uart_tx_arb: N_REQ must be 1..8 and TIMEOUT at least 1");
  end

  arb_state_t             state;
  logic [IDX_W-1:0]       last_gnt;
  logic [N_REQ-1:0]       pick_gnt;
  logic [IDX_W-1:0]       pick_idx;
  logic                   pick_any;
  logic                   slot_free;
  logic                   accept;
  logic                   sel_last;
  logic [UART_BYTE_W-1:0] sel_data;
  logic                   tx_val_next;
  logic                   release_lock;
  logic                   timeout_hit;

  rr_arbiter #(
    .N_REQ(N_REQ)
  ) u_rr (
    .req     (req_val_i),
    .last_gnt(last_gnt),
    .gnt     (pick_gnt),
    .gnt_idx (pick_idx),
    .any     (pick_any)
  );

  // Mux the owner's byte and handshake; grant_o is one-hot so an OR-mux suffices.
  always_comb begin
    sel_data = {UART_BYTE_W{1'b0}};
    sel_last = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      sel_data = sel_data | (req_data_i[i*UART_BYTE_W +: UART_BYTE_W] & {UART_BYTE_W{grant_o[i]}});
      sel_last = sel_last | (req_last_i[i] & grant_o[i]);
    end
    slot_free    = !tx_val_o || tx_rdy_i;
    req_rdy_o    = ((state == LOCK) && slot_free) ? grant_o : {N_REQ{1'b0}};
    accept       = |(req_val_i & req_rdy_o);
    tx_val_next  = accept || (tx_val_o && !tx_rdy_i);
    release_lock = (state == LOCK) && ((accept && sel_last) || timeout_hit);
  end

`ifdef UART_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] stall_cnt;
  logic             granted_val;

  assign granted_val = |(req_val_i & grant_o);
  assign timeout_hit = (state == LOCK) && !granted_val && (stall_cnt == CNT_W'(TIMEOUT - 1));

  // Count owner-idle cycles while locked; a byte-in-hand waiting on the UART is not a stall.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= {CNT_W{1'b0}};
    end else if ((state != LOCK) || accept || timeout_hit) begin
      stall_cnt <= {CNT_W{1'b0}};
    end else if (!granted_val) begin
      stall_cnt <= stall_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      stall_cnt <= stall_cnt;
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  // Arbitration FSM, output byte register and status flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ARB;
      grant_o   <= {N_REQ{1'b0}};
      last_gnt  <= LAST_RST;
      tx_val_o  <= 1'b0;
      tx_data_o <= {UART_BYTE_W{1'b0}};
      busy_o    <= 1'b0;
      timeout_o <= 1'b0;
    end else begin
      tx_val_o  <= tx_val_next;
      timeout_o <= timeout_hit;
      if (accept) begin
        tx_data_o <= sel_data;
      end else begin
        tx_data_o <= tx_data_o;
      end
      case (state)
        ARB: begin
          if (pick_any) begin
            state    <= LOCK;
            grant_o  <= pick_gnt;
            last_gnt <= pick_idx;
            busy_o   <= 1'b1;
          end else begin
            state    <= ARB;
            busy_o   <= tx_val_next;
          end
        end
        LOCK: begin
          if (release_lock) begin
            state   <= ARB;
            grant_o <= {N_REQ{1'b0}};
            busy_o  <= tx_val_next;
          end else begin
            state   <= LOCK;
            busy_o  <= 1'b1;
          end
        end
        default: begin
          state   <= ARB;
          grant_o <= {N_REQ{1'b0}};
          busy_o  <= tx_val_next;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arb.sv
// Directed self-checking bench for uart_tx_arb (N_REQ=4, TIMEOUT=16).
module tb_uart_tx_arb;

  logic        clk;
  logic        rst;
  logic [3:0]  req_val;
  logic [31:0] req_data;
  logic [3:0]  req_last;
  logic [3:0]  req_rdy;
  logic        tx_val;
  logic [7:0]  tx_data;
  logic        tx_rdy;
  logic [3:0]  grant;
  logic        busy;
  logic        timeout;

  int checks = 0;
  int failures = 0;

  logic [7:0] mem [4][64];
  int         sent [4];
  int         total [4];
  int         pkt_len [4];
  logic [3:0] en;
  logic [3:0] stall;
  int         hold;
  int         hold_len;
  logic [7:0] rx [$];
  int         unstable;
  int         pulses;
  logic       prev_val;
  logic       prev_xfer;
  logic [7:0] prev_data;
  int         bad;
  logic [7:0] exp_fair [10];
  int         stall_len;

  uart_tx_arb #(.N_REQ(4), .TIMEOUT(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_val_i (req_val),
    .req_data_i(req_data),
    .req_last_i(req_last),
    .req_rdy_o (req_rdy),
    .tx_val_o  (tx_val),
    .tx_data_o (tx_data),
    .tx_rdy_i  (tx_rdy),
    .grant_o   (grant),
    .busy_o    (busy),
    .timeout_o (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tb_clear();
    en = 4'b0000; stall = 4'b0000; hold = 0; hold_len = 0;
    unstable = 0; pulses = 0; prev_val = 1'b0; prev_xfer = 1'b0; prev_data = 8'h00;
    rx.delete();
    for (int i = 0; i < 4; i++) begin
      sent[i] = 0; total[i] = 0; pkt_len[i] = 64;
      for (int k = 0; k < 64; k++) mem[i][k] = 8'h00;
    end
  endtask

  // One clock: drive requesters and UART ready, sample at negedge, account after posedge.
  task automatic tick();
    logic [3:0] acc;
    logic       xfer;
    for (int i = 0; i < 4; i++) begin
      req_val[i] = en[i] && !stall[i] && (sent[i] < total[i]);
      req_data[8*i +: 8] = mem[i][sent[i] % 64];
      req_last[i] = (((sent[i] + 1) % pkt_len[i]) == 0) || ((sent[i] + 1) == total[i]);
    end
    tx_rdy = (hold == 0);
    @(negedge clk);
    acc  = req_val & req_rdy;
    xfer = tx_val && tx_rdy;
    if (xfer) rx.push_back(tx_data);
    if (prev_val && !prev_xfer && !(tx_val === 1'b1 && tx_data === prev_data)) unstable++;
    prev_val  = tx_val && !rst;
    prev_xfer = xfer;
    prev_data = tx_data;
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) sent[i] += int'(acc[i]);
    if (xfer) hold = hold_len;
    else if (hold > 0) hold--;
    if (timeout) pulses++;
  endtask

  task automatic reset_dut();
    en = 4'b0000;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tb_clear();
  endtask

  initial begin
    rst = 1'b1; req_val = 4'b0000; req_data = 32'h0; req_last = 4'b0000; tx_rdy = 1'b1;
    tb_clear();
    @(posedge clk);
    #1;
    reset_dut();

    // Reset state
    check("rst_tx_val", 32'(tx_val), 32'h0);
    check("rst_tx_data", 32'(tx_data), 32'h0);
    check("rst_grant", 32'(grant), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_timeout", 32'(timeout), 32'h0);
    check("rst_req_rdy", 32'(req_rdy), 32'h0);

    // Single packet from requester 0
    mem[0][0] = 8'h48; mem[0][1] = 8'h69; total[0] = 2; pkt_len[0] = 2; en[0] = 1'b1;
    tick();
    check("p0_grant", 32'(grant), 32'h1);
    check("p0_busy", 32'(busy), 32'h1);
    check("p0_noval", 32'(tx_val), 32'h0);
    tick();
    check("p0_b0_val", 32'(tx_val), 32'h1);
    check("p0_b0_data", 32'(tx_data), 32'h48);
    tick();
    check("p0_b1_data", 32'(tx_data), 32'h69);
    check("p0_released", 32'(grant), 32'h0);
    tick();
    check("p0_drained", 32'(tx_val), 32'h0);
    check("p0_idle", 32'(busy), 32'h0);
    check("p0_rx_cnt", 32'(rx.size()), 32'd2);
    // Requester 0 just won, so requester 1 is next even with 0 asking too
    mem[0][2] = 8'h01; mem[0][3] = 8'h02; total[0] = 4;
    mem[1][0] = 8'h03; total[1] = 1; en[1] = 1'b1;
    tick();
    check("rr_after_0", 32'(grant), 32'h2);

    // Fairness: all four stream 2-byte packets
    reset_dut();
    for (int i = 0; i < 4; i++) begin
      for (int k = 0; k < 4; k++) mem[i][k] = 8'(i * 16 + k);
      total[i] = 4; pkt_len[i] = 2;
    end
    en = 4'b1111;
    exp_fair = '{8'h00, 8'h01, 8'h10, 8'h11, 8'h20, 8'h21, 8'h30, 8'h31, 8'h02, 8'h03};
    for (int c = 0; c < 200 && rx.size() < 10; c++) tick();
    check("fair_count", 32'(rx.size()), 32'd10);
    for (int i = 0; i < 10; i++) begin
      check($sformatf("fair_byte%0d", i), (i < rx.size()) ? 32'(rx[i]) : 32'hDEAD, 32'(exp_fair[i]));
    end

    // Slow UART: ready drops for 20 cycles after each transfer
    reset_dut();
    for (int k = 0; k < 64; k++) mem[2][k] = 8'(k * 3 + 7);
    total[2] = 64; pkt_len[2] = 8; hold_len = 20; en[2] = 1'b1;
    for (int c = 0; c < 3000 && rx.size() < 64; c++) tick();
    repeat (30) tick();
    check("slow_count", 32'(rx.size()), 32'd64);
    check("slow_stable", 32'(unstable), 32'd0);
    bad = 0;
    for (int k = 0; k < 64; k++) begin
      if (k >= rx.size() || rx[k] !== 8'(k * 3 + 7)) bad++;
    end
    check("slow_sequence", 32'(bad), 32'd0);

    // Stalled owner keeps its lock
    reset_dut();
`ifdef UART_ARB_TIMEOUT_EN
    stall_len = 10;
`else
    stall_len = 50;
`endif
    mem[2][0] = 8'hA5; mem[2][1] = 8'h5A; total[2] = 2; pkt_len[2] = 2; en[2] = 1'b1;
    tick();
    check("stall_grant2", 32'(grant), 32'h4);
    tick();
    stall[2] = 1'b1;
    mem[1][0] = 8'h11; mem[1][1] = 8'h12; total[1] = 2; pkt_len[1] = 2; en[1] = 1'b1;
    bad = 0;
    repeat (stall_len) begin
      tick();
      if (grant !== 4'b0100 || req_rdy[1] !== 1'b0) bad++;
    end
    check("stall_held", 32'(bad), 32'd0);
    stall[2] = 1'b0;
    tick();
    check("stall_last_rel", 32'(grant), 32'h0);
    tick();
    check("stall_grant1", 32'(grant), 32'h2);
    repeat (4) tick();
    check("stall_rx_cnt", 32'(rx.size()), 32'd4);
    check("stall_rx0", (rx.size() > 0) ? 32'(rx[0]) : 32'hDEAD, 32'hA5);
    check("stall_rx1", (rx.size() > 1) ? 32'(rx[1]) : 32'hDEAD, 32'h5A);
    check("stall_rx2", (rx.size() > 2) ? 32'(rx[2]) : 32'hDEAD, 32'h11);
    check("stall_rx3", (rx.size() > 3) ? 32'(rx[3]) : 32'hDEAD, 32'h12);

    // Reset while a byte is pending on a stalled UART
    reset_dut();
    mem[3][0] = 8'hC1; mem[3][1] = 8'hC2; mem[3][2] = 8'hC3; total[3] = 3; pkt_len[3] = 3;
    en[3] = 1'b1; hold = 100;
    tick();
    tick();
    check("mid_tx_val", 32'(tx_val), 32'h1);
    check("mid_tx_data", 32'(tx_data), 32'hC1);
    check("mid_grant", 32'(grant), 32'h8);
    en = 4'b0000;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_rst_val", 32'(tx_val), 32'h0);
    check("mid_rst_grant", 32'(grant), 32'h0);
    check("mid_rst_busy", 32'(busy), 32'h0);
    tb_clear();
    total[0] = 1; total[3] = 1; en = 4'b1001;
    tick();
    check("mid_rst_rr0", 32'(grant), 32'h1);

`ifdef UART_ARB_TIMEOUT_EN
    // Timeout: 15 idle cycles tolerated, the 16th forces a release
    reset_dut();
    mem[0][0] = 8'h31; mem[0][1] = 8'h32; mem[0][2] = 8'h33; total[0] = 3; pkt_len[0] = 3;
    mem[1][0] = 8'h41; total[1] = 1;
    en = 4'b0011;
    tick();
    check("to_grant0", 32'(grant), 32'h1);
    tick();
    stall[0] = 1'b1;
    repeat (15) tick();
    check("to_15_nopulse", 32'(pulses), 32'd0);
    check("to_15_held", 32'(grant), 32'h1);
    stall[0] = 1'b0;
    tick();
    check("to_resume_sent", 32'(sent[0]), 32'd2);
    stall[0] = 1'b1;
    repeat (15) tick();
    check("to_b_nopulse", 32'(pulses), 32'd0);
    tick();
    check("to_pulse", 32'(timeout), 32'h1);
    check("to_released", 32'(grant), 32'h0);
    tick();
    check("to_pulse_once", 32'(pulses), 32'd1);
    check("to_next_grant", 32'(grant), 32'h2);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
